// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's load/store port.
// Takes one request at a time and performs RV32I byte/half/word loads and stores
// on an internal little-endian word array. It answers after a configurable number
// of wait states.
// Optional build macro DMEM_PERF_CNT_EN adds load/store/error handshake counters.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
`ifdef DMEM_PERF_CNT_EN
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
  output logic [31:0]       err_count,
`endif
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0] wait_cnt;

  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic              accept, enter_resp, do_write, fault;
  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rd_word, ld_data, wr_lanes;
  logic [3:0]        wr_be;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Control FSM: request acceptance, wait-state countdown and response hold
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 4'd1) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (next_state == RESP) && (state != RESP);
  assign do_write   = enter_resp && acc_we && !fault && !reset;

  // With zero wait states the access happens on the accept edge, so use the live request
  always_comb begin
    if (state == IDLE) begin
      acc_we     = req_we;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = lat_we;
      acc_funct3 = lat_funct3;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
    end
  end

  // Fault decode, load lane extraction/extension and store lane placement
  always_comb begin
    word_idx = acc_addr[ADDR_W-1:2];
    rd_word  = mem[word_idx[IDX_W-1:0]];
    ld_byte  = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    ld_half  = rd_word[{acc_addr[1], 4'b0000} +: 16];

    fault = 1'b0;
    case (acc_funct3)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = acc_addr[0];
      3'b010:         fault = (acc_addr[1:0] != 2'b00);
      default:        fault = 1'b1;
    endcase
    if (acc_we && acc_funct3[2]) fault = 1'b1;
    if ({1'b0, word_idx} >= DEPTH_LIM) fault = 1'b1;

    ld_data = 32'd0;
    case (acc_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
    if (fault || acc_we) ld_data = 32'd0;

    wr_be    = 4'b0000;
    wr_lanes = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        wr_be    = 4'b0001 << acc_addr[1:0];
        wr_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = acc_wdata;
      end
    endcase
  end

  // State, request latch, wait counter and captured response
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_we     <= req_we;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        wait_cnt   <= WAIT_INIT;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= ld_data;
        err_q   <= fault;
      end
    end
  end

  // Byte-lane writes into the word array; contents survive reset
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[word_idx[IDX_W-1:0]][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef DMEM_PERF_CNT_EN
  logic rsp_fire;
  assign rsp_fire = (state == RESP) && rsp_ready;

  // Per-type response handshake counters; faulted accesses count only as errors
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_count  <= 32'd0;
      st_count  <= 32'd0;
      err_count <= 32'd0;
    end else if (rsp_fire) begin
      if (err_q)       err_count <= err_count + 32'd1;
      else if (lat_we) st_count  <= st_count + 32'd1;
      else             ld_count  <= ld_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against
// a byte-array memory model. Build with DMEM_PERF_CNT_EN to also cover the counters.
module tb_dmem_responder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int WC     = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] ld_count, st_count, err_count;
`endif

  dmem_responder #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
`ifdef DMEM_PERF_CNT_EN
    .ld_count(ld_count),
    .st_count(st_count),
    .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ld   = 0;
  int exp_st   = 0;
  int exp_err  = 0;

  logic [7:0] ref_mem [DEPTH*4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Reference model: byte-addressed memory, sizes and extension from the RV32I rules
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int unsigned size;
    longint      val;
    int          base;
    err   = 1'b0;
    rdata = 32'd0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 0; err = 1'b1; end
    endcase
    if (we && f3 >= 3'd4) err = 1'b1;
    if (size != 0 && (addr % size) != 0) err = 1'b1;
    if ((addr / 4) >= DEPTH) err = 1'b1;
    if (err) return;
    base = int'(addr);
    if (we) begin
      for (int i = 0; i < int'(size); i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
    end else begin
      val = 0;
      for (int i = 0; i < int'(size); i++) val = val + (longint'(ref_mem[base + i]) << (8 * i));
      if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val - (64'sd1 << (8 * size));
      rdata = val[31:0];
    end
  endtask

  task automatic scramble();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One full transaction: accept, latency, optional response stall, handshake
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int stall, input logic hold_valid,
                               output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_rdata;
    logic        exp_e;
    int          cyc;
    checkFlag("idle_req_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock); #1;
    modelAccess(we, f3, addr, wdata, exp_rdata, exp_e);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc <= WC + 8) begin
      checkFlag("wait_req_ready", req_ready, 1'b0);
      checkFlag("wait_busy", busy, 1'b1);
      scramble();
      @(posedge clock); #1;
      cyc++;
    end
    checkOutput("latency", cyc, WC + 1);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkFlag("rsp_err", rsp_err, exp_e);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int i = 0; i < stall; i++) begin
      scramble();
      req_valid = 1'b1;
      @(posedge clock); #1;
      checkFlag("stall_rsp_valid", rsp_valid, 1'b1);
      checkOutput("stall_rsp_rdata", rsp_rdata, exp_rdata);
      checkFlag("stall_rsp_err", rsp_err, exp_e);
      checkFlag("stall_req_ready", req_ready, 1'b0);
    end
    scramble();
    req_valid = hold_valid;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkFlag("post_rsp_valid", rsp_valid, 1'b0);
    checkFlag("post_busy", busy, 1'b0);
    checkFlag("post_req_ready", req_ready, 1'b1);
    if (exp_e)   exp_err++;
    else if (we) exp_st++;
    else         exp_ld++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r, old;
    logic        e;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkFlag("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkFlag("reset_rsp_err", rsp_err, 1'b0);
    checkFlag("reset_busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkFlag("reset_req_ready", req_ready, 1'b1);

    $display("[TB] filling memory");
    for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 3'd2, 32'(w * 4), $urandom, 0, 1'b0, r, e);

    $display("[TB] word store and load");
    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, r, e);
    checkFlag("t1_sw_err", e, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, r, e);
    checkOutput("t1_lw", r, 32'hDEADBEEF);
    checkFlag("t1_lw_err", e, 1'b0);

    $display("[TB] sub-word accesses");
    applyStimulus(1'b1, 3'd0, 32'h13, 32'h00000080, 0, 1'b0, r, e);
    applyStimulus(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0, r, e);
    checkOutput("t2_lb", r, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0, r, e);
    checkOutput("t2_lbu", r, 32'h00000080);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, r, e);
    checkOutput("t2_lw", r, 32'h80ADBEEF);
    applyStimulus(1'b0, 3'd5, 32'h12, 32'h0, 0, 1'b0, r, e);
    checkOutput("t2_lhu", r, 32'h000080AD);

    $display("[TB] faults");
    applyStimulus(1'b0, 3'd1, 32'h11, 32'h0, 0, 1'b0, r, e);
    checkFlag("t3_lh_mis_err", e, 1'b1);
    checkOutput("t3_lh_mis_rdata", r, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h00, 32'h0, 0, 1'b0, old, e);
    applyStimulus(1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 0, 1'b0, r, e);
    checkFlag("t3_sw_mis_err", e, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h00, 32'h0, 0, 1'b0, r, e);
    checkOutput("t3_no_write", r, old);
    applyStimulus(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 0, 1'b0, r, e);
    checkFlag("t3_oor_err", e, 1'b1);
    applyStimulus(1'b0, 3'd3, 32'h08, 32'h0, 0, 1'b0, r, e);
    checkFlag("t3_f3_011_err", e, 1'b1);
    applyStimulus(1'b1, 3'd4, 32'h08, 32'h55, 0, 1'b0, r, e);
    checkFlag("t3_sbu_err", e, 1'b1);

    $display("[TB] response backpressure");
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1, r, e);
    checkOutput("t4_lw", r, 32'h80ADBEEF);

    $display("[TB] reset during wait");
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, old, e);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    checkFlag("t5_in_wait", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkFlag("t5_busy", busy, 1'b0);
    checkFlag("t5_rsp_valid", rsp_valid, 1'b0);
    checkFlag("t5_req_ready", req_ready, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, r, e);
    checkOutput("t5_lw_old", r, old);

    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'hCAFEF00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (WC - 1) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkFlag("t5b_busy", busy, 1'b0);
    exp_ld  = 0;
    exp_st  = 0;
    exp_err = 0;
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, r, e);
    checkOutput("t5b_lw_old", r, old);

    applyStimulus(1'b0, 3'd2, 32'h24, 32'h0, 0, 1'b0, r, e);
    applyStimulus(1'b0, 3'd4, 32'h21, 32'h0, 0, 1'b0, r, e);
    applyStimulus(1'b1, 3'd2, 32'h30, 32'h01020304, 0, 1'b0, r, e);
    applyStimulus(1'b1, 3'd0, 32'h31, 32'h000000AA, 1, 1'b0, r, e);
    applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 0, 1'b0, r, e);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("t6_ld_count", ld_count, 32'd3);
    checkOutput("t6_st_count", st_count, 32'd2);
    checkOutput("t6_err_count", err_count, 32'd1);
`endif

    $display("[TB] randomized transactions");
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    f3 = 3'd0;
        2, 3:    f3 = 3'd1;
        4, 5:    f3 = 3'd2;
        6:       f3 = 3'd4;
        7:       f3 = 3'd5;
        default: f3 = 3'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else                            a = 32'($urandom_range(0, DEPTH * 4 + 7));
      applyStimulus(1'($urandom), f3, a, $urandom, int'($urandom_range(0, 3)),
                    1'($urandom), r, e);
    end

`ifdef DMEM_PERF_CNT_EN
    checkOutput("final_ld_count", ld_count, 32'(exp_ld));
    checkOutput("final_st_count", st_count, 32'(exp_st));
    checkOutput("final_err_count", err_count, 32'(exp_err));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
